led_frame_scheduler: RTL and testbench
======================================

Name: led_frame_scheduler

Overview:
- Double-buffered frame store and scan scheduler that sits between the game logic and the 16x16 bicolour LED display driver.
- Game logic draws into a back buffer through a pixel-write port. The block drives the driver's pixel arrays from the front buffer and generates the driver's row-advance enable.
- Buffer swaps take effect only at a full-scan boundary, so the display never shows a torn frame.
- Also provides a sequenced back-buffer clear.

Parameters:
- FREQDIV, 15, must equal the driver's FREQDIV; one frame = 16 * 2^FREQDIV row-advance enables.
- SPDW, 10, width of the Speed divider input.
- COPY_ON_SWAP, 1, if 1, the new back buffer is loaded with the new front contents after each swap.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- Speed  in  SPDW  EnableCount period minus one, in CLK cycles
- Wr_En  in  1  write one pixel to the back buffer
- Wr_Row  in  4  first index of the written pixel
- Wr_Col  in  4  second index of the written pixel
- Wr_Color  in  2  bit0 = red, bit1 = green (00 = off, 11 = both)
- Clear_Req  in  1  pulse: zero the back buffer
- Swap_Req  in  1  level: request front/back swap, held until Swap_Ack
- Swap_Ack  out  1  one-cycle pulse when the swap has taken effect
- Busy  out  1  high while state is not IDLE
- RedPixels  out  16x16  front-buffer red plane, to the driver
- GrnPixels  out  16x16  front-buffer green plane, to the driver
- EnableCount  out  1  row-advance pulse, to the driver
- FrameStart  out  1  one-cycle pulse at the start of each scan frame

Behaviour:
- Reset:
  - Both buffers cleared; front select = 0.
  - Divider, scan counter and FSM return to IDLE/zero.
  - EnableCount, FrameStart, Swap_Ack and Busy are all 0.
  - Pixel outputs are all 0.
  - Reset mid-clear, mid-wait or mid-copy abandons the operation; no Swap_Ack is issued.
- Divider:
  - Count increments each cycle.
  - When count >= Speed, EnableCount = 1 (registered) and count returns to 0; otherwise EnableCount = 0.
  - Period is Speed+1 cycles; Speed=0 gives EnableCount every cycle.
  - A Speed change takes effect on the next comparison.
- Scan counter:
  - Width FREQDIV+4; increments on each EnableCount, mirroring the driver's internal counter.
  - The driver must be reset in the same cycle as this block.
- Wrap event: EnableCount=1 and scan counter all ones. FrameStart pulses in the cycle after the wrap, when scan = 0.
- Pixel outputs: combinational select of the front buffer using the registered front select.
- FSM, IDLE:
  - Wr_En: back[Wr_Row][Wr_Col] red/green bits take Wr_Color at the next edge.
  - Clear_Req has priority over Swap_Req: go to CLEAR. A concurrent Wr_En is dropped.
  - Swap_Req (no Clear_Req): go to WAIT_SWAP. A Wr_En in that same cycle is still performed.
- FSM, CLEAR:
  - Zeroes one back-buffer row per cycle, index 0..15; 16 cycles total, then IDLE.
  - Wr_En is ignored; Swap_Req stays pending and is sampled again in IDLE.
- FSM, WAIT_SWAP:
  - Writes are ignored.
  - On the wrap-event edge, front select toggles. Swap_Ack pulses in the following cycle.
  - Next state is COPY if COPY_ON_SWAP=1, else IDLE.
- FSM, COPY:
  - One cycle; the whole back buffer is loaded from the new front buffer, then IDLE.
  - Swap_Ack and COPY share the same cycle.
- Handshake:
  - The requester must drop Swap_Req in the Swap_Ack cycle.
  - If Swap_Req is still high when IDLE is re-entered, a second swap begins.
  - Clear_Req is honoured only while Busy=0; a pulse while Busy=1 is dropped.
- Out-of-range: none possible; all indices are 4-bit.

Test Plan:
- Divider: FREQDIV=0, Speed=3 after reset -> EnableCount pulses every 4 cycles; FrameStart every 64 cycles. Speed=0 -> EnableCount continuous, FrameStart every 16 cycles.
- Write then swap: write Wr_Row=2, Wr_Col=3, Wr_Color=11 and Wr_Row=1, Wr_Col=1, Wr_Color=01, then hold Swap_Req.
  - Outputs stay 0 until the wrap; Swap_Ack arrives in the FrameStart cycle.
  - Then RedPixels[2][3]=GrnPixels[2][3]=1 and RedPixels[1][1]=1; all other pixels 0.
- COPY_ON_SWAP=1: after the first swap, write Wr_Row=5, Wr_Col=5, Wr_Color=10 and swap again -> front shows the previous three pixels plus GrnPixels[5][5]=1.
  - With COPY_ON_SWAP=0: the second swap shows only [5][5] plus whatever the reset-cleared buffer held.
- Clear: fill the back buffer, pulse Clear_Req together with Swap_Req and Wr_En.
  - Busy is high for exactly 16 cycles and the write is dropped.
  - The swap then proceeds and the display goes fully dark.
- Writes while busy: Wr_En during CLEAR and during WAIT_SWAP -> back buffer unchanged (checked after the next swap).
- Reset mid-WAIT_SWAP: assert RST for 1 cycle -> no Swap_Ack; outputs, Busy and EnableCount are 0; front select = 0.

Source files
------------

// File: rtl/led_frame_scheduler_if.sv
// rtl/led_frame_scheduler_if.sv - game-logic side pixel-write / clear / swap port
interface led_frame_scheduler_if;
    logic       Wr_En;
    logic [3:0] Wr_Row;
    logic [3:0] Wr_Col;
    logic [1:0] Wr_Color;
    logic       Clear_Req;
    logic       Swap_Req;
    logic       Swap_Ack;
    logic       Busy;

    modport master (
        output Wr_En, Wr_Row, Wr_Col, Wr_Color, Clear_Req, Swap_Req,
        input  Swap_Ack, Busy
    );

    modport slave (
        input  Wr_En, Wr_Row, Wr_Col, Wr_Color, Clear_Req, Swap_Req,
        output Swap_Ack, Busy
    );
endinterface

// File: rtl/led_frame_scheduler.sv
// rtl/led_frame_scheduler.sv - double-buffered 16x16 bicolour frame store and scan scheduler
// Swaps land only on the scan wrap so the driver never shows a torn frame.
module led_frame_scheduler #(
    parameter int FREQDIV      = 15,
    parameter int SPDW         = 10,
    parameter int COPY_ON_SWAP = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [SPDW-1:0]       Speed,
    led_frame_scheduler_if.slave  bus,
    output logic [15:0][15:0]     RedPixels,
    output logic [15:0][15:0]     GrnPixels,
    output logic                  EnableCount,
    output logic                  FrameStart
);
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_WAIT_SWAP, S_COPY} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [SPDW-1:0]     r_div;
    logic                r_en;
    logic [FREQDIV+3:0]  r_scan;
    logic                r_frame_start;
    logic                r_front;
    logic                r_swap_ack;
    logic [3:0]          r_clr_row;
    logic [15:0][15:0]   r_red [2];
    logic [15:0][15:0]   r_grn [2];
    logic                w_wrap;
    logic                w_back;

    // Scan counter mirrors the driver's own counter, so wrap marks the end of a full scan.
    assign w_wrap = r_en && (&r_scan);
    assign w_back = ~r_front;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_div         <= '0;
            r_en          <= 1'b0;
            r_scan        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            if (r_div >= Speed) begin
                r_div <= '0;
                r_en  <= 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
                r_en  <= 1'b0;
            end
            if (r_en)
                r_scan <= r_scan + 1'b1;
            r_frame_start <= w_wrap;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.Clear_Req)
                    w_next = S_CLEAR;
                else if (bus.Swap_Req)
                    w_next = S_WAIT_SWAP;
            end
            S_CLEAR:     if (r_clr_row == 4'd15) w_next = S_IDLE;
            S_WAIT_SWAP: if (w_wrap) w_next = (COPY_ON_SWAP != 0) ? S_COPY : S_IDLE;
            S_COPY:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_front    <= 1'b0;
            r_swap_ack <= 1'b0;
            r_clr_row  <= '0;
            r_red[0]   <= '0;
            r_red[1]   <= '0;
            r_grn[0]   <= '0;
            r_grn[1]   <= '0;
        end else begin
            r_swap_ack <= (r_state == S_WAIT_SWAP) && w_wrap;
            r_clr_row  <= (r_state == S_CLEAR) ? r_clr_row + 4'd1 : 4'd0;
            case (r_state)
                S_IDLE: begin
                    if (bus.Wr_En && !bus.Clear_Req) begin
                        r_red[w_back][bus.Wr_Row][bus.Wr_Col] <= bus.Wr_Color[0];
                        r_grn[w_back][bus.Wr_Row][bus.Wr_Col] <= bus.Wr_Color[1];
                    end
                end
                S_CLEAR: begin
                    r_red[w_back][r_clr_row] <= '0;
                    r_grn[w_back][r_clr_row] <= '0;
                end
                S_WAIT_SWAP: begin
                    if (w_wrap)
                        r_front <= ~r_front;
                end
                S_COPY: begin
                    // r_front already points at the new front here, w_back at the new back.
                    r_red[w_back] <= r_red[r_front];
                    r_grn[w_back] <= r_grn[r_front];
                end
                default: ;
            endcase
        end
    end

    assign RedPixels    = r_red[r_front];
    assign GrnPixels    = r_grn[r_front];
    assign EnableCount  = r_en;
    assign FrameStart   = r_frame_start;
    assign bus.Busy     = (r_state != S_IDLE);
    assign bus.Swap_Ack = r_swap_ack;
endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb/tb_led_frame_scheduler.sv - scoreboard bench for led_frame_scheduler
module tb_led_frame_scheduler;
    localparam int FREQDIV = 0;
    localparam int SPDW    = 10;
    localparam int COPY    = 1;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [SPDW-1:0]     Speed = '0;
    logic [15:0][15:0]   RedPixels;
    logic [15:0][15:0]   GrnPixels;
    logic                EnableCount;
    logic                FrameStart;

    led_frame_scheduler_if bus();

    led_frame_scheduler #(.FREQDIV(FREQDIV), .SPDW(SPDW), .COPY_ON_SWAP(COPY)) dut (
        .CLK(CLK), .RST(RST), .Speed(Speed), .bus(bus),
        .RedPixels(RedPixels), .GrnPixels(GrnPixels),
        .EnableCount(EnableCount), .FrameStart(FrameStart)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    logic [15:0][15:0] m_front_r, m_front_g, m_back_r, m_back_g;
    logic [511:0]      exp_q[$];
    logic [511:0]      mon_e;

    // Monitor: every Swap_Ack must match the oldest outstanding swap and coincide with FrameStart.
    always @(negedge CLK) begin
        if (!RST && bus.Swap_Ack) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ack: Swap_Ack=1 with no swap outstanding, required 0");
            end else begin
                mon_e = exp_q.pop_front();
                if ({RedPixels, GrnPixels} !== mon_e) begin
                    fails++;
                    $display("FAIL front_after_swap: got %h required %h", {RedPixels, GrnPixels}, mon_e);
                end
            end
            tests++;
            if (FrameStart !== 1'b1) begin
                fails++;
                $display("FAIL ack_framestart: FrameStart=%0b in ack cycle, required 1", FrameStart);
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic check_pix(input string nm, input logic [511:0] exp);
        tests++;
        if ({RedPixels, GrnPixels} !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, {RedPixels, GrnPixels}, exp);
        end
    endtask

    task automatic model_reset();
        m_front_r = '0; m_front_g = '0; m_back_r = '0; m_back_g = '0;
    endtask

    task automatic rand_fields();
        bus.Wr_Row   = 4'($urandom_range(0, 15));
        bus.Wr_Col   = 4'($urandom_range(0, 15));
        bus.Wr_Color = 2'($urandom_range(0, 3));
    endtask

    task automatic do_write(input logic [3:0] r, input logic [3:0] c, input logic [1:0] col);
        bus.Wr_En = 1'b1; bus.Wr_Row = r; bus.Wr_Col = c; bus.Wr_Color = col;
        tick();
        bus.Wr_En = 1'b0;
        m_back_r[r][c] = col[0];
        m_back_g[r][c] = col[1];
    endtask

    task automatic do_swap(input bit noise);
        logic [15:0][15:0] tr, tg;
        bit got;
        tr = m_front_r; tg = m_front_g;
        m_front_r = m_back_r; m_front_g = m_back_g;
        if (COPY == 0) begin
            m_back_r = tr; m_back_g = tg;
        end
        exp_q.push_back({m_front_r, m_front_g});
        bus.Swap_Req = 1'b1;
        tick();
        check_pix("front_before_wrap", {tr, tg});
        got = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            if (bus.Swap_Ack) begin
                got = 1'b1;
                break;
            end
            if (noise && bus.Busy) begin
                bus.Wr_En = 1'b1;
                rand_fields();
                bus.Clear_Req = 1'($urandom_range(0, 1));
            end
            tick();
            bus.Wr_En = 1'b0;
            bus.Clear_Req = 1'b0;
        end
        check("swap_ack_seen", int'(got), 1);
        bus.Swap_Req = 1'b0;
        tick();
    endtask

    task automatic wait_sig(input bit which_fs, input string nm);
        int n;
        n = 0;
        while (((which_fs ? FrameStart : EnableCount) !== 1'b1) && n < 4000) begin
            tick();
            n++;
        end
        if (n >= 4000) begin
            tests++; fails++;
            $display("FAIL %s_timeout: no pulse within 4000 cycles, required one", nm);
        end
    endtask

    task automatic measure(input int spd);
        int n;
        Speed = SPDW'(spd);
        wait_sig(1'b0, "en");
        n = 0;
        do begin tick(); n++; end while (EnableCount !== 1'b1 && n < 1000);
        check("en_period", n, spd + 1);
        wait_sig(1'b1, "fs");
        n = 0;
        do begin tick(); n++; end while (FrameStart !== 1'b1 && n < 4000);
        check("frame_period", n, 16 * (spd + 1));
    endtask

    initial begin
        int n, first_en;
        bus.Wr_En = 0; bus.Wr_Row = 0; bus.Wr_Col = 0; bus.Wr_Color = 0;
        bus.Clear_Req = 0; bus.Swap_Req = 0;
        Speed = 10'd3;
        model_reset();
        repeat (3) tick();
        RST = 1'b0;
        check("rst_busy", int'(bus.Busy), 0);
        check("rst_en", int'(EnableCount), 0);
        check("rst_fs", int'(FrameStart), 0);
        check("rst_ack", int'(bus.Swap_Ack), 0);
        check_pix("rst_pixels", '0);

        n = 0; first_en = -1;
        while (FrameStart !== 1'b1 && n < 500) begin
            tick(); n++;
            if (EnableCount === 1'b1 && first_en < 0) first_en = n;
        end
        check("first_en_edges", first_en, 4);
        check("first_fs_edges", n, 65);

        measure(0);
        for (int i = 0; i < 3; i++) measure(int'($urandom_range(1, 7)));

        Speed = 10'd0;
        do_write(4'd2, 4'd3, 2'b11);
        do_write(4'd1, 4'd1, 2'b01);
        do_swap(1'b0);
        do_write(4'd5, 4'd5, 2'b10);
        do_swap(1'b0);

        for (int r = 0; r < 4; r++) begin
            int nw;
            nw = int'($urandom_range(1, 8));
            for (int w = 0; w < nw; w++)
                do_write(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            do_swap(1'($urandom_range(0, 1)));
        end

        for (int w = 0; w < 10; w++)
            do_write(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3)));
        bus.Clear_Req = 1'b1; bus.Swap_Req = 1'b1;
        bus.Wr_En = 1'b1; bus.Wr_Row = 4'd7; bus.Wr_Col = 4'd7; bus.Wr_Color = 2'b11;
        tick();
        bus.Clear_Req = 1'b0; bus.Swap_Req = 1'b0; bus.Wr_En = 1'b0;
        m_back_r = '0; m_back_g = '0;
        n = 0;
        while (bus.Busy && n < 100) begin
            n++;
            bus.Wr_En = 1'b1;
            rand_fields();
            tick();
        end
        bus.Wr_En = 1'b0;
        check("clear_busy_cycles", n, 16);
        do_swap(1'b1);
        check_pix("dark_after_clear", '0);

        Speed = 10'd60;
        wait_sig(1'b1, "fs_pre_rst");
        bus.Swap_Req = 1'b1;
        repeat (3) tick();
        check("busy_in_wait", int'(bus.Busy), 1);
        RST = 1'b1; bus.Swap_Req = 1'b0;
        tick();
        RST = 1'b0;
        model_reset();
        check("midrst_busy", int'(bus.Busy), 0);
        check("midrst_en", int'(EnableCount), 0);
        check("midrst_ack", int'(bus.Swap_Ack), 0);
        check_pix("midrst_pixels", '0);
        repeat (40) tick();

        Speed = 10'd0;
        do_write(4'd15, 4'd0, 2'b01);
        do_write(4'd0, 4'd15, 2'b10);
        do_swap(1'b0);

        repeat (5) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
